// File: rtl/sim_status_monitor.sv
// sim_status_monitor
// Collects stdout characters and pass/fail/exit status from NUM_CH cores.
// Each channel has its own line buffer. Whole lines leave through one
// round-robin arbitrated output stream. Per-channel results are folded into
// one sticky verdict, guarded by a run-time programmable cycle watchdog.
//
// Optional feature macro: SIM_STATUS_PRINT_EN
//   defined   -> popped chars are echoed with $write, each line prefixed "[chN] ",
//                and the verdict is announced with $display on DONE entry.
//   undefined -> no system tasks; port behaviour is identical.
//
// Handshake (both char streams): a transfer happens on a rising clk_i edge
// where valid and ready are both 1. While valid is 1 and ready is 0, the
// producer holds its data stable. The monitor's out_* stream follows this
// rule, and ready never depends on valid.
module sim_status_monitor #(
  parameter int NUM_CH         = 2,
  parameter int LINE_BUF_DEPTH = 64,
  parameter int EXIT_W         = 32,
  parameter int CNT_W          = 32,
  localparam int CH_W          = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  localparam int PTR_W         = $clog2(LINE_BUF_DEPTH)
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic [CNT_W-1:0]         max_cycles_i,
  input  logic [NUM_CH-1:0]        print_valid_i,
  input  logic [NUM_CH*8-1:0]      print_wdata_i,
  output logic [NUM_CH-1:0]        print_ready_o,
  input  logic [NUM_CH-1:0]        tests_passed_i,
  input  logic [NUM_CH-1:0]        tests_failed_i,
  input  logic [NUM_CH-1:0]        exit_valid_i,
  input  logic [NUM_CH*EXIT_W-1:0] exit_value_i,
  output logic                     out_valid_o,
  input  logic                     out_ready_i,
  output logic [CH_W-1:0]          out_ch_o,
  output logic [7:0]               out_char_o,
  output logic [NUM_CH-1:0]        ch_done_o,
  output logic                     done_o,
  output logic                     pass_o,
  output logic                     fail_o,
  output logic                     timeout_o,
  output logic [CH_W-1:0]          first_fail_ch_o,
  output logic [EXIT_W-1:0]        exit_value_o,
  output logic [CNT_W-1:0]         cycle_cnt_o,
  output logic [1:0]               state_o
);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t state_q, state_d;

  // Per-channel line buffers
  logic [7:0]     mem      [NUM_CH][LINE_BUF_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q [NUM_CH];
  logic [PTR_W-1:0] rd_ptr_q [NUM_CH];
  logic [PTR_W:0]   cnt_q    [NUM_CH];
  logic [PTR_W:0]   nl_cnt_q [NUM_CH];

  logic [NUM_CH-1:0] full, empty, eligible, push, pop;

  // Arbiter
  logic            grant_q;
  logic [CH_W-1:0] grant_ch_q, last_ch_q;
  logic            pick_valid;
  logic [CH_W-1:0] pick_ch;
  logic            pop_fire, line_release;

  // Status
  logic [NUM_CH-1:0] ch_done_q, ch_fail_q;
  logic [NUM_CH-1:0] ev_pass, ev_fail, new_fail;
  logic              ff_seen_q;
  logic [CH_W-1:0]   ff_ch_q, ff_pick_ch;
  logic [EXIT_W-1:0] ff_exit_q, ff_pick_exit;
  logic              timeout_q, timeout_hit, fail_any, flush;
  logic [CNT_W-1:0]  cycle_cnt_q;

  // FIFO flags, eligibility and push acceptance per channel
  always_comb begin
    full          = '0;
    empty         = '0;
    eligible      = '0;
    print_ready_o = '0;
    push          = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      full[k]          = (cnt_q[k] == (PTR_W+1)'(LINE_BUF_DEPTH));
      empty[k]         = (cnt_q[k] == '0);
      eligible[k]      = (nl_cnt_q[k] != '0) || full[k] || (ch_done_q[k] && !empty[k]);
      print_ready_o[k] = !full[k] && (state_q != ST_DONE);
      push[k]          = print_valid_i[k] && print_ready_o[k];
    end
  end

  // Output stream is read straight from the granted buffer head
  always_comb begin
    out_ch_o    = grant_ch_q;
    out_char_o  = mem[grant_ch_q][rd_ptr_q[grant_ch_q]];
    out_valid_o = grant_q && !empty[grant_ch_q] && (state_q != ST_DONE);
    pop_fire    = out_valid_o && out_ready_i;
    pop         = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      pop[k] = pop_fire && (grant_ch_q == CH_W'(k));
    end
    // A line ends at its newline, or when its buffer runs dry without a refill
    line_release = pop_fire &&
                   ((out_char_o == 8'h0A) ||
                    ((cnt_q[grant_ch_q] == (PTR_W+1)'(1)) && !push[grant_ch_q]));
  end

  // Round-robin search starting just after the last granted channel
  always_comb begin
    pick_valid = 1'b0;
    pick_ch    = '0;
    for (int i = 1; i <= NUM_CH; i++) begin
      int idx;
      idx = (int'(last_ch_q) + i) % NUM_CH;
      if (!pick_valid && eligible[idx]) begin
        pick_valid = 1'b1;
        pick_ch    = CH_W'(idx);
      end
    end
  end

  // Status events; a channel's first event decides its result
  always_comb begin
    ev_pass      = '0;
    ev_fail      = '0;
    new_fail     = '0;
    ff_pick_ch   = '0;
    ff_pick_exit = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      ev_fail[k]  = tests_failed_i[k] ||
                    (exit_valid_i[k] && (exit_value_i[EXIT_W*k +: EXIT_W] != '0));
      ev_pass[k]  = tests_passed_i[k] ||
                    (exit_valid_i[k] && (exit_value_i[EXIT_W*k +: EXIT_W] == '0));
      new_fail[k] = ev_fail[k] && !ch_done_q[k] && (state_q != ST_DONE);
    end
    // Lowest index wins among channels failing in the same cycle
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      if (new_fail[k]) begin
        ff_pick_ch   = CH_W'(k);
        ff_pick_exit = exit_valid_i[k] ? exit_value_i[EXIT_W*k +: EXIT_W] : '0;
      end
    end
  end

  assign timeout_hit = (max_cycles_i != '0) && (cycle_cnt_q >= max_cycles_i) &&
                       (state_q != ST_DONE);
  assign flush       = (state_d == ST_DONE);

  // Next-state logic: watchdog overrides normal completion
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN: begin
        if (timeout_hit)       state_d = ST_DONE;
        else if (&ch_done_q)   state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (timeout_hit)                 state_d = ST_DONE;
        else if ((&empty) && !grant_q)   state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_DONE;
      default: state_d = ST_RUN;
    endcase
  end

  // State register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= ST_RUN;
    else         state_q <= state_d;
  end

  // Character storage; not reset, since occupancy is tracked by the counters
  always_ff @(posedge clk_i) begin
    for (int k = 0; k < NUM_CH; k++) begin
      if (push[k]) mem[k][wr_ptr_q[k]] <= print_wdata_i[8*k +: 8];
    end
  end

  // Buffer pointers, occupancy and newline counts; emptied on DONE entry
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int k = 0; k < NUM_CH; k++) begin
        wr_ptr_q[k] <= '0;
        rd_ptr_q[k] <= '0;
        cnt_q[k]    <= '0;
        nl_cnt_q[k] <= '0;
      end
    end else if (flush) begin
      for (int k = 0; k < NUM_CH; k++) begin
        wr_ptr_q[k] <= '0;
        rd_ptr_q[k] <= '0;
        cnt_q[k]    <= '0;
        nl_cnt_q[k] <= '0;
      end
    end else begin
      for (int k = 0; k < NUM_CH; k++) begin
        if (push[k]) wr_ptr_q[k] <= wr_ptr_q[k] + 1'b1;
        if (pop[k])  rd_ptr_q[k] <= rd_ptr_q[k] + 1'b1;
        cnt_q[k]    <= cnt_q[k] + (PTR_W+1)'(push[k]) - (PTR_W+1)'(pop[k]);
        nl_cnt_q[k] <= nl_cnt_q[k]
                       + (PTR_W+1)'(push[k] && (print_wdata_i[8*k +: 8] == 8'h0A))
                       - (PTR_W+1)'(pop[k] && (out_char_o == 8'h0A));
      end
    end
  end

  // Grant is taken on an eligible channel and held until the line ends
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      grant_q    <= 1'b0;
      grant_ch_q <= '0;
      last_ch_q  <= CH_W'(NUM_CH - 1);
    end else if (flush) begin
      grant_q    <= 1'b0;
    end else if (grant_q) begin
      if (line_release) grant_q <= 1'b0;
    end else if (pick_valid) begin
      grant_q    <= 1'b1;
      grant_ch_q <= pick_ch;
      last_ch_q  <= pick_ch;
    end
  end

  // Per-channel result latch plus the one-shot first-failure record
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ch_done_q <= '0;
      ch_fail_q <= '0;
      ff_seen_q <= 1'b0;
      ff_ch_q   <= '0;
      ff_exit_q <= '0;
    end else if (state_q != ST_DONE) begin
      for (int k = 0; k < NUM_CH; k++) begin
        if (!ch_done_q[k] && (ev_pass[k] || ev_fail[k])) begin
          ch_done_q[k] <= 1'b1;
          ch_fail_q[k] <= ev_fail[k];
        end
      end
      if (!ff_seen_q && (|new_fail)) begin
        ff_seen_q <= 1'b1;
        ff_ch_q   <= ff_pick_ch;
        ff_exit_q <= ff_pick_exit;
      end
    end
  end

  // Cycle counter and sticky watchdog flag; counting stops at DONE
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cycle_cnt_q <= '0;
      timeout_q   <= 1'b0;
    end else begin
      if (timeout_hit) timeout_q <= 1'b1;
      if ((state_q != ST_DONE) && !timeout_hit && (cycle_cnt_q != '1))
        cycle_cnt_q <= cycle_cnt_q + 1'b1;
    end
  end

  assign fail_any        = timeout_q || (|(ch_done_q & ch_fail_q));
  assign done_o          = (state_q == ST_DONE);
  assign fail_o          = fail_any;
  assign pass_o          = done_o && !fail_any;
  assign timeout_o       = timeout_q;
  assign ch_done_o       = ch_done_q;
  assign first_fail_ch_o = ff_ch_q;
  assign exit_value_o    = ff_exit_q;
  assign cycle_cnt_o     = cycle_cnt_q;
  assign state_o         = state_q;

`ifdef SIM_STATUS_PRINT_EN
  logic line_first_q;

  // Remember that the next pop starts a fresh line, so it gets a prefix
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)                            line_first_q <= 1'b0;
    else if (!grant_q && pick_valid)        line_first_q <= 1'b1;
    else if (pop_fire)                      line_first_q <= 1'b0;
  end

  // Echo popped characters and announce the verdict once
  always_ff @(posedge clk_i) begin
    if (rst_ni) begin
      if (pop_fire) begin
        if (line_first_q) $write("[ch%0d] ", grant_ch_q);
        $write("%c", out_char_o);
      end
      if ((state_q != ST_DONE) && (state_d == ST_DONE)) begin
        $display("sim_status_monitor: verdict=%s cycles=%0d first_fail_ch=%0d exit=%0d",
                 (fail_any || timeout_hit || (|new_fail)) ? "fail" : "pass",
                 cycle_cnt_q, ff_seen_q ? ff_ch_q : ff_pick_ch,
                 ff_seen_q ? ff_exit_q : ff_pick_exit);
      end
    end
  end
`else
  // Silent build: no system tasks, the ports behave exactly as above.
`endif

endmodule
